// File: rtl/dmem_responder_if.sv
// RAM-side request/acknowledge bus of the data-memory responder.
// master = responder (drives strobes), slave = RAM (returns data and ack).
interface dmem_responder_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_responder.sv
// MEM-stage responder: runs the data-RAM handshake for loads/stores, stalls the
// front of the pipeline while busy, and hands results plus write-back fields to MEM/WB.
//
// state | meaning
// IDLE  | accept a new op: pass-through if no request, else capture and go BUSY
// BUSY  | strobes held on the RAM bus, waiting for mem_ack or timeout
module dmem_responder #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        DataAddress,
  input  logic [15:0]        DataIn,
  input  logic               ReadMem,
  input  logic               WriteMem,
  input  logic [1:0]         quarter,
  input  logic               write,
  input  logic [3:0]         writeReg,
  output logic               stall,
  dmem_responder_if.master   mem,
  output logic [15:0]        o_ReadData,
  output logic [15:0]        o_DataAddress,
  output logic [1:0]         o_quarter,
  output logic               o_write,
  output logic [3:0]         o_writeReg,
  output logic               o_valid,
  output logic               err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [1:0]  cap_quarter_q;
  logic        cap_write_q;
  logic [3:0]  cap_writeReg_q;
  logic [15:0] rdata_q;
  logic [15:0] daddr_q;
  logic [1:0]  quarter_q;
  logic        write_q;
  logic [3:0]  writeReg_q;
  logic        valid_q;
  logic        err_q;

  logic req;
  logic timeout_hit;

  assign req         = ReadMem | WriteMem;
  assign timeout_hit = (state_q == BUSY) && !mem.mem_ack && (cnt_q == CNT_LAST);
  // The upstream latch advances on the completing edge, so stall drops in the ack/timeout cycle.
  assign stall       = ((state_q == IDLE) && req) ||
                       ((state_q == BUSY) && !mem.mem_ack && !timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      cap_quarter_q  <= '0;
      cap_write_q    <= 1'b0;
      cap_writeReg_q <= '0;
      rdata_q        <= '0;
      daddr_q        <= '0;
      quarter_q      <= '0;
      write_q        <= 1'b0;
      writeReg_q     <= '0;
      valid_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            mem_addr_q     <= DataAddress;
            mem_wdata_q    <= DataIn;
            mem_rd_q       <= ReadMem & ~WriteMem;
            mem_wr_q       <= WriteMem;
            cap_quarter_q  <= quarter;
            cap_write_q    <= write;
            cap_writeReg_q <= writeReg;
            cnt_q          <= '0;
            err_q          <= ReadMem & WriteMem;
            state_q        <= BUSY;
          end else begin
            daddr_q    <= DataAddress;
            quarter_q  <= quarter;
            write_q    <= write;
            writeReg_q <= writeReg;
            valid_q    <= 1'b1;
          end
        end
        BUSY: begin
          if (mem.mem_ack || timeout_hit) begin
            daddr_q    <= mem_addr_q;
            quarter_q  <= cap_quarter_q;
            writeReg_q <= cap_writeReg_q;
            valid_q    <= 1'b1;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            state_q    <= IDLE;
            if (mem.mem_ack) begin
              write_q <= cap_write_q;
              if (mem_rd_q) rdata_q <= mem.mem_rdata;
            end else begin
              // Aborted access: poison the data and suppress the register write.
              write_q <= 1'b0;
              rdata_q <= 16'hFFFF;
              err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_rd    = mem_rd_q;
  assign mem.mem_wr    = mem_wr_q;

  assign o_ReadData    = rdata_q;
  assign o_DataAddress = daddr_q;
  assign o_quarter     = quarter_q;
  assign o_write       = write_q;
  assign o_writeReg    = writeReg_q;
  assign o_valid       = valid_q;
  assign err           = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-stage data-memory responder. It sits between the EX/MEM pipeline latch and a single-port external data RAM with a request/acknowledge handshake. It accepts the load/store request presented by the latch, runs the RAM handshake, and stalls the front of the pipeline until the access completes or times out. It then hands read data plus the register write-back fields to the MEM/WB stage.

## Interface
- TIMEOUT, 16: cycles in BUSY without mem_ack before the access is aborted; legal range 2..255.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- DataAddress  in  16  load/store address, or ALU result for non-memory instructions.
- DataIn  in  16  store data.
- ReadMem  in  1  load request.
- WriteMem  in  1  store request.
- quarter  in  2  register-file quarter select, passed to write-back.
- write  in  1  register write enable, passed to write-back.
- writeReg  in  4  destination register, passed to write-back.
- stall  out  1  combinational; holds the EX/MEM latch and upstream stages.
- mem_addr  out  16  RAM address, registered.
- mem_wdata  out  16  RAM write data, registered.
- mem_rd  out  1  RAM read strobe, registered, held until ack or abort.
- mem_wr  out  1  RAM write strobe, registered, held until ack or abort.
- mem_rdata  in  16  RAM read data, valid with mem_ack.
- mem_ack  in  1  RAM completion, one or more cycles.
- o_ReadData  out  16  load result.
- o_DataAddress  out  16  forwarded DataAddress (ALU result path).
- o_quarter  out  2  forwarded quarter.
- o_write  out  1  forwarded write enable; forced 0 on abort.
- o_writeReg  out  4  forwarded writeReg.
- o_valid  out  1  one-cycle pulse: write-back fields valid.
- err  out  1  one-cycle pulse: timeout abort, or ReadMem and WriteMem both set.

## Operation
- States: IDLE and BUSY. Reset enters IDLE.
- **IDLE with no request** (ReadMem=0, WriteMem=0):
  - The next edge registers DataAddress, quarter, write and writeReg to the o_* outputs.
  - o_valid=1 for one cycle; o_ReadData keeps its previous value.
  - stall=0. This is the pass-through path.
- **IDLE with a request**:
  - stall=1.
  - The next edge loads mem_addr=DataAddress and mem_wdata=DataIn.
  - It also captures quarter, write and writeReg internally, and sets mem_rd=ReadMem&~WriteMem and mem_wr=WriteMem.
  - The state moves to BUSY and the timeout counter clears to 0.
- **ReadMem and WriteMem both set**: the write wins, and err pulses in the cycle after capture.
- **BUSY, mem_ack=1**:
  - stall=0 in that cycle.
  - On the edge: o_ReadData=mem_rdata (load only; unchanged on a store), captured fields go to the o_* outputs, o_valid=1.
  - mem_rd and mem_wr drop to 0 and the state returns to IDLE.
- **BUSY, no ack**: the counter increments and stall=1.
- **Timeout** (counter==TIMEOUT-1 and mem_ack=0):
  - stall=0 in that cycle.
  - On the edge: o_ReadData=16'hFFFF, o_write=0, o_valid=1, err=1, strobes drop, and the state returns to IDLE.
- mem_ack in IDLE is ignored.
- Counter width is 8 bits; it never wraps because it is cleared at capture.

## Timing
- **Reset values**:
  - All o_* outputs, mem_* outputs and err are 0.
  - stall is 0 because the state is IDLE and no request is present.
  - Assertion takes effect immediately, mid-access included: strobes drop without waiting for ack and no o_valid is produced.
- **Pass-through latency**: 1 cycle.
- **Memory access latency**:
  - The request is captured at edge N and strobes are high after N.
  - The earliest ack is in cycle N..N+1, giving o_valid after edge N+1, a minimum of 2 cycles.
  - In general o_valid follows the edge on which ack is sampled.
- **stall equation**: (IDLE & (ReadMem|WriteMem)) | (BUSY & ~mem_ack & ~timeout_hit).
  - The upstream latch advances on the completing edge.
  - A back-to-back request is captured in the following IDLE cycle, so the responder accepts at most one memory op per 2 cycles.
- mem_addr, mem_wdata and the strobes are stable for the whole of BUSY.

## Test plan
- **Reset**: assert rst_n=0 mid-BUSY -> mem_rd=0 immediately; o_valid, stall and err are 0; after release, a pass-through op produces o_valid one cycle later.
- **Pass-through**: DataAddress=16'h1234, write=1, writeReg=4'h5, quarter=2'b10 -> one cycle later o_DataAddress=16'h1234, o_writeReg=5, o_quarter=2, o_valid=1, stall never high.
- **Load, ack on 3rd BUSY cycle**: ReadMem=1 at address 16'h0040, mem_rdata=16'hBEEF -> mem_addr=16'h0040 and mem_rd=1 for 3 cycles, stall high 3 cycles then low in the ack cycle, then o_ReadData=16'hBEEF and o_valid=1.
- **Store with immediate ack**: WriteMem=1, DataIn=16'hA5A5, mem_ack high the first BUSY cycle -> mem_wr one cycle with mem_wdata=16'hA5A5, o_valid 2 cycles after presentation, o_ReadData unchanged.
- **Timeout** with TIMEOUT=4, no ack -> exactly 4 BUSY cycles, then err=1, o_valid=1, o_ReadData=16'hFFFF, o_write=0, and the next request is accepted.
- **Conflict and back-to-back**: ReadMem=WriteMem=1 -> mem_wr=1, mem_rd=0, err pulse; a second load queued behind it is captured the cycle after completion with no request lost.
